// File: rtl/y_window_pkg.sv
// Shared constants and helpers for the 5-tap vertical window filter.
// Y_WINDOW_ROUND_EN selects round-half-up instead of truncation in the final scaling.
package y_window_pkg;

   localparam int PIX_W     = 8;
   localparam int ACC_W     = 18;
   localparam int SHIFT     = 8;
   localparam int ROWS_FULL = 4;

   localparam int H0_DEF = 6;
   localparam int H1_DEF = 58;
   localparam int H2_DEF = 128;

   function automatic int addr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   // Scale the weighted sum back to pixel range and clamp at full scale.
   function automatic logic [PIX_W-1:0] scale_sat(input logic [ACC_W-1:0] s);
      logic [ACC_W-1:0] shifted;
`ifdef Y_WINDOW_ROUND_EN
      shifted = (s + ACC_W'(1 << (SHIFT - 1))) >> SHIFT;
`else
      shifted = s >> SHIFT;
`endif
      if (shifted > ACC_W'((1 << PIX_W) - 1)) begin
         return {PIX_W{1'b1}};
      end
      return shifted[PIX_W-1:0];
   endfunction

endpackage

// File: rtl/y_line_buffer.sv
// One image row of storage: asynchronous read of the old word, write on the clock edge,
// so a read and write at the same address return the previous row's pixel.
module y_line_buffer
   import y_window_pkg::*;
#(
   parameter int DEPTH = 640,
   parameter int WIDTH = PIX_W
) (
   input  logic                         clock,
   input  logic                         we,
   input  logic [addr_width(DEPTH)-1:0] addr,
   input  logic [WIDTH-1:0]             wdata,
   output logic [WIDTH-1:0]             rdata
);

   logic [WIDTH-1:0] mem [0:DEPTH-1];

   assign rdata = mem[addr];

   always_ff @(posedge clock) begin
      if (we) begin
         mem[addr] <= wdata;
      end
   end

endmodule

// File: rtl/y_window.sv
// 5-tap vertical filter over four cascaded line buffers with a 3-stage non-stalling pipeline.
// Define Y_WINDOW_ROUND_EN to round the output instead of truncating it.
module y_window
   import y_window_pkg::*;
#(
   parameter int H0         = H0_DEF,
   parameter int H1         = H1_DEF,
   parameter int H2         = H2_DEF,
   parameter int LINE_WIDTH = 640
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [PIX_W-1:0] din,
   input  logic             validin,
   input  logic             sof,
   output logic [PIX_W-1:0] dout,
   output logic             validout
);

   localparam int COL_W = addr_width(LINE_WIDTH);

   logic [COL_W-1:0] col;
   logic [COL_W-1:0] cur_col;
   logic [2:0]       rows_done;
   logic [2:0]       cur_rows;
   logic             accept;
   logic             qualify;

   logic [PIX_W-1:0] tap [0:4];

   logic [PIX_W:0]   sum04;
   logic [PIX_W:0]   sum13;
   logic [PIX_W-1:0] mid;
   logic             valid1;

   logic [ACC_W-1:0] prod0;
   logic [ACC_W-1:0] prod1;
   logic [ACC_W-1:0] prod2;
   logic             valid2;

   // A start-of-frame pixel is treated as row 0, column 0 regardless of the counters.
   always_comb begin
      accept   = validin & ~reset;
      cur_col  = sof ? '0 : col;
      cur_rows = sof ? '0 : rows_done;
      qualify  = accept && (cur_rows == 3'(ROWS_FULL));
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         col       <= '0;
         rows_done <= '0;
      end else if (validin) begin
         if (cur_col == COL_W'(LINE_WIDTH - 1)) begin
            col       <= '0;
            rows_done <= (cur_rows == 3'(ROWS_FULL)) ? cur_rows : cur_rows + 3'd1;
         end else begin
            col       <= cur_col + COL_W'(1);
            rows_done <= cur_rows;
         end
      end
   end

   assign tap[0] = din;

   // Each buffer hands its old row down the cascade while storing the newer one.
   for (genvar k = 0; k < 4; k++) begin : g_lines
      y_line_buffer #(
         .DEPTH (LINE_WIDTH),
         .WIDTH (PIX_W)
      ) u_line (
         .clock (clock),
         .we    (accept),
         .addr  (cur_col),
         .wdata (tap[k]),
         .rdata (tap[k+1])
      );
   end

   always_ff @(posedge clock) begin
      sum04 <= {1'b0, tap[0]} + {1'b0, tap[4]};
      sum13 <= {1'b0, tap[1]} + {1'b0, tap[3]};
      mid   <= tap[2];
      prod0 <= ACC_W'(H0) * ACC_W'(sum04);
      prod1 <= ACC_W'(H1) * ACC_W'(sum13);
      prod2 <= ACC_W'(H2) * ACC_W'(mid);
   end

   // Reset drops in-flight results; dout only moves when a result emerges.
   always_ff @(posedge clock) begin
      if (reset) begin
         valid1   <= 1'b0;
         valid2   <= 1'b0;
         validout <= 1'b0;
         dout     <= '0;
      end else begin
         valid1   <= qualify;
         valid2   <= valid1;
         validout <= valid2;
         if (valid2) begin
            dout <= scale_sat(prod0 + prod1 + prod2);
         end
      end
   end

endmodule

// File: tb/tb_y_window.sv
// Self-checking bench for y_window (LINE_WIDTH=8) against a frame-history reference model.
// Honours Y_WINDOW_ROUND_EN the same way as the design.
module tb_y_window;

   localparam int LW = 8;
   localparam int H0 = 6;
   localparam int H1 = 58;
   localparam int H2 = 128;

   logic       clock;
   logic       reset;
   logic [7:0] din;
   logic       validin;
   logic       sof;
   logic [7:0] dout;
   logic       validout;

   int n_cmp  = 0;
   int n_fail = 0;

   int         edge_idx = 0;
   bit         exp_v [0:4095];
   logic [7:0] exp_d [0:4095];
   logic [7:0] last_dout = 8'd0;
   bit         now_v = 1'b0;
   logic [7:0] hist [$];

   y_window #(
      .H0         (H0),
      .H1         (H1),
      .H2         (H2),
      .LINE_WIDTH (LW)
   ) dut (
      .clock    (clock),
      .reset    (reset),
      .din      (din),
      .validin  (validin),
      .sof      (sof),
      .dout     (dout),
      .validout (validout)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Filter value for the pixel about to join the frame history, straight from the weights.
   function automatic logic [7:0] model_pixel(input int n, input logic [7:0] d);
      int p [0:4];
      int s;
      p[0] = d;
      for (int k = 1; k <= 4; k++) p[k] = hist[n - k*LW];
      s = H0*(p[0] + p[4]) + H1*(p[1] + p[3]) + H2*p[2];
`ifdef Y_WINDOW_ROUND_EN
      s = s + 128;
`endif
      s = s / 256;
      if (s > 255) s = 255;
      return 8'(s);
   endfunction

   // Drives one cycle, advances the model, and leaves now_v/last_dout as the expected outputs.
   task automatic tick(input logic v, input logic [7:0] d, input logic s, input logic r);
      int n;
      validin = v;
      din     = d;
      sof     = s;
      reset   = r;
      @(posedge clock);
      if (r) begin
         hist.delete();
         for (int k = 0; k < 3; k++) exp_v[edge_idx + k] = 1'b0;
         last_dout = 8'd0;
      end else if (v) begin
         if (s) hist.delete();
         n = hist.size();
         if (n >= 4*LW) begin
            exp_v[edge_idx + 2] = 1'b1;
            exp_d[edge_idx + 2] = model_pixel(n, d);
         end
         hist.push_back(d);
      end
      now_v = exp_v[edge_idx];
      if (now_v) last_dout = exp_d[edge_idx];
      edge_idx++;
      #1;
   endtask

   task automatic test_reset();
      tick(1'b0, 8'd0, 1'b0, 1'b1);
      tick(1'b0, 8'd0, 1'b0, 1'b1);
      n_cmp++;
      if (validout !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL reset_valid: got %b want 0", validout);
      end
      n_cmp++;
      if (dout !== 8'd0) begin
         n_fail++;
         $display("[TB] FAIL reset_dout: got %0d want 0", dout);
      end
      tick(1'b0, 8'd0, 1'b0, 1'b0);
   endtask

   task automatic test_constant();
      int pulses = 0;
      for (int i = 0; i < 6*LW + 3; i++) begin
         if (i < 6*LW) tick(1'b1, 8'd100, i == 0, 1'b0);
         else          tick(1'b0, 8'd0, 1'b0, 1'b0);
         n_cmp++;
         if (validout !== now_v) begin
            n_fail++;
            $display("[TB] FAIL const_valid i=%0d: got %b want %b", i, validout, now_v);
         end
         if (validout === 1'b1) begin
            pulses++;
            n_cmp++;
            if (dout !== 8'd100) begin
               n_fail++;
               $display("[TB] FAIL const_dout i=%0d: got %0d want 100", i, dout);
            end
         end
      end
      n_cmp++;
      if (pulses !== 16) begin
         n_fail++;
         $display("[TB] FAIL const_pulses: got %0d want 16", pulses);
      end
   endtask

   task automatic test_impulse();
      logic [7:0] tbl [0:4];
      int p = 0;
`ifdef Y_WINDOW_ROUND_EN
      tbl = '{8'd6, 8'd58, 8'd128, 8'd58, 8'd6};
`else
      tbl = '{8'd5, 8'd57, 8'd127, 8'd57, 8'd5};
`endif
      for (int i = 0; i < 9*LW + 3; i++) begin
         if (i < 9*LW) tick(1'b1, (i / LW == 4) ? 8'd255 : 8'd0, i == 0, 1'b0);
         else          tick(1'b0, 8'd0, 1'b0, 1'b0);
         n_cmp++;
         if (validout !== now_v || dout !== last_dout) begin
            n_fail++;
            $display("[TB] FAIL impulse_model i=%0d: got v=%b d=%0d want v=%b d=%0d",
                     i, validout, dout, now_v, last_dout);
         end
         if (validout === 1'b1 && p < 40) begin
            n_cmp++;
            if (dout !== tbl[p / LW]) begin
               n_fail++;
               $display("[TB] FAIL impulse_row%0d: got %0d want %0d", 4 + p / LW, dout, tbl[p / LW]);
            end
            p++;
         end
      end
      n_cmp++;
      if (p !== 40) begin
         n_fail++;
         $display("[TB] FAIL impulse_pulses: got %0d want 40", p);
      end
   endtask

   task automatic test_saturate();
      for (int i = 0; i < 6*LW + 3; i++) begin
         if (i < 6*LW) tick(1'b1, 8'd255, i == 0, 1'b0);
         else          tick(1'b0, 8'd0, 1'b0, 1'b0);
         n_cmp++;
         if (validout !== now_v) begin
            n_fail++;
            $display("[TB] FAIL sat_valid i=%0d: got %b want %b", i, validout, now_v);
         end
         if (validout === 1'b1) begin
            n_cmp++;
            if (dout !== 8'd255) begin
               n_fail++;
               $display("[TB] FAIL sat_dout i=%0d: got %0d want 255", i, dout);
            end
         end
      end
   endtask

   task automatic test_gaps();
      bit qual_hist [$];
      int accepted = 0;
      for (int i = 0; i < 12*LW + 3; i++) begin
         logic v;
         v = (i < 12*LW) && (i % 2 == 0);
         tick(v, 8'($urandom_range(0, 255)), i == 0, 1'b0);
         qual_hist.push_back(v && accepted >= 4*LW);
         if (v) accepted++;
         n_cmp++;
         if (validout !== now_v || dout !== last_dout) begin
            n_fail++;
            $display("[TB] FAIL gaps_model i=%0d: got v=%b d=%0d want v=%b d=%0d",
                     i, validout, dout, now_v, last_dout);
         end
         if (i >= 2) begin
            n_cmp++;
            if (validout !== qual_hist[i - 2]) begin
               n_fail++;
               $display("[TB] FAIL gaps_delay i=%0d: got %b want %b", i, validout, qual_hist[i - 2]);
            end
         end
      end
   endtask

   task automatic test_mid_reset();
      for (int i = 0; i < 5*LW + 3; i++) tick(1'b1, 8'($urandom_range(0, 255)), i == 0, 1'b0);
      tick(1'b1, 8'd200, 1'b0, 1'b1);
      n_cmp++;
      if (validout !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL midreset_valid: got %b want 0", validout);
      end
      for (int i = 0; i < 4*LW + 2; i++) begin
         if (i < 4*LW) tick(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
         else          tick(1'b0, 8'd0, 1'b0, 1'b0);
         n_cmp++;
         if (validout !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL midreset_quiet i=%0d: got %b want 0", i, validout);
         end
      end
      for (int i = 0; i < 2*LW + 3; i++) begin
         if (i < 2*LW) tick(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
         else          tick(1'b0, 8'd0, 1'b0, 1'b0);
         n_cmp++;
         if (validout !== now_v || dout !== last_dout) begin
            n_fail++;
            $display("[TB] FAIL midreset_resume i=%0d: got v=%b d=%0d want v=%b d=%0d",
                     i, validout, dout, now_v, last_dout);
         end
      end
   endtask

   task automatic test_sof_restart();
      for (int i = 0; i < 6*LW; i++) tick(1'b1, 8'($urandom_range(0, 255)), i == 0, 1'b0);
      for (int i = 0; i < 4*LW + 2; i++) begin
         if (i < 4*LW) tick(1'b1, 8'($urandom_range(0, 255)), i == 0, 1'b0);
         else          tick(1'b0, 8'd0, 1'b0, 1'b0);
         n_cmp++;
         if (validout !== now_v || dout !== last_dout) begin
            n_fail++;
            $display("[TB] FAIL sof_model i=%0d: got v=%b d=%0d want v=%b d=%0d",
                     i, validout, dout, now_v, last_dout);
         end
         if (i >= 2) begin
            n_cmp++;
            if (validout !== 1'b0) begin
               n_fail++;
               $display("[TB] FAIL sof_quiet i=%0d: got %b want 0", i, validout);
            end
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         logic v, s, r;
         v = ($urandom % 4) != 0;
         s = v && (i == 0 || ($urandom % 64) == 0);
         r = (i > 0) && ($urandom % 250) == 0;
         tick(v, 8'($urandom_range(0, 255)), s, r);
         n_cmp++;
         if (validout !== now_v || dout !== last_dout) begin
            n_fail++;
            $display("[TB] FAIL random i=%0d: got v=%b d=%0d want v=%b d=%0d",
                     i, validout, dout, now_v, last_dout);
         end
      end
   endtask

   initial begin
      validin = 1'b0;
      din     = 8'd0;
      sof     = 1'b0;
      reset   = 1'b1;
      test_reset();
      test_constant();
      test_impulse();
      test_saturate();
      test_gaps();
      test_mid_reset();
      test_sof_restart();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
